// File: rtl/spi_resp_regs.sv
// rtl/spi_resp_regs.sv - SPI mode-0 responder turning 16-bit frames into register read/write strobes
//
// Frame (MSB first): bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = write data / don't-care.
// Optional feature macro: SPI_RESP_ABORT_CNT_EN (saturating count of aborted frames on abort_cnt).
//
// Ports:
//   clk125      in   system clock, only clock of the block
//   rst         in   asynchronous active-low reset
//   spi_csn     in   chip select, active-low, asynchronous to clk125
//   spi_sck     in   SPI clock (CPOL=0, CPHA=0), asynchronous to clk125
//   spi_sdi     in   master-to-responder data
//   spi_sdo     out  responder-to-master data
//   spi_sdo_oe  out  SDO drive enable, high while selected
//   wr_en       out  one-cycle write strobe, with wr_addr / wr_data
//   rd_req      out  one-cycle read strobe, with rd_addr
//   rd_data     in   combinational read data, sampled while rd_req is high
//   abort_cnt   out  aborted-frame count (0 when the feature is not built)
module spi_resp_regs #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk125,
    input  logic              rst,
    input  logic              spi_csn,
    input  logic              spi_sck,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        abort_cnt
);

    localparam int             CMD_BITS   = 1 + ADDR_W;
    localparam int             FW         = CMD_BITS + DATA_W;
    localparam logic [4:0]     CMD_LAST   = 5'(CMD_BITS - 1);
    localparam logic [4:0]     FRAME_LAST = 5'(FW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic csn_s1, csn_s2, csn_d;
    logic sck_s1, sck_s2, sck_d;
    logic sdi_s1, sdi_s2;
    logic [1:0] vld;
    logic armed;

    logic csn_fall, csn_rise, sck_rise, sck_fall;
    logic rd_fire, wr_fire;

    logic [4:0]        bit_cnt;
    logic [FW-2:0]     rx;
    logic [FW-1:0]     frame_now;
    logic [DATA_W-1:0] tx;
    logic              tx_act;

    // Input synchronizers. The synchronizers come out of reset showing CSN high,
    // which is not a real observation; vld/armed make sure a CSN fall is only
    // accepted after CSN has genuinely been seen high, so a reset released
    // mid-frame does not start a bogus frame.
    always_ff @(posedge clk125 or negedge rst) begin
        if (!rst) begin
            csn_s1 <= 1'b1;
            csn_s2 <= 1'b1;
            csn_d  <= 1'b1;
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_d  <= 1'b0;
            sdi_s1 <= 1'b0;
            sdi_s2 <= 1'b0;
            vld    <= 2'b00;
            armed  <= 1'b0;
        end else begin
            csn_s1 <= spi_csn;
            csn_s2 <= csn_s1;
            csn_d  <= csn_s2;
            sck_s1 <= spi_sck;
            sck_s2 <= sck_s1;
            sck_d  <= sck_s2;
            sdi_s1 <= spi_sdi;
            sdi_s2 <= sdi_s1;
            vld    <= {vld[0], 1'b1};
            armed  <= armed | (vld[1] & csn_s2);
        end
    end

    assign csn_fall   = armed & csn_d & ~csn_s2;
    assign csn_rise   = csn_s2 & ~csn_d;
    assign sck_rise   = sck_s2 & ~sck_d;
    assign sck_fall   = ~sck_s2 & sck_d;
    assign spi_sdo_oe = ~csn_s2;

    // Frame as it stands including the bit arriving on this SCK rise.
    assign frame_now  = {rx, sdi_s2};

    always_ff @(posedge clk125 or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        if (csn_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (csn_fall) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (sck_rise && bit_cnt == CMD_LAST) begin
                        state_d = DATA;
                        rd_fire = frame_now[CMD_BITS-1];
                    end
                end
                DATA: begin
                    if (sck_rise && bit_cnt == FRAME_LAST) begin
                        state_d = DONE;
                        wr_fire = ~frame_now[FW-1];
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Receive shift register and bit counter.
    always_ff @(posedge clk125 or negedge rst) begin
        if (!rst) begin
            bit_cnt <= 5'd0;
            rx      <= '0;
        end else if (csn_fall) begin
            bit_cnt <= 5'd0;
            rx      <= '0;
        end else if (sck_rise && (state_q == CMD || state_q == DATA)) begin
            bit_cnt <= bit_cnt + 5'd1;
            rx      <= frame_now[FW-2:0];
        end
    end

    // Register-side strobes, one cycle after the deciding SCK rise.
    always_ff @(posedge clk125 or negedge rst) begin
        if (!rst) begin
            rd_req  <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            rd_req <= rd_fire;
            wr_en  <= wr_fire;
            if (rd_fire) begin
                rd_addr <= frame_now[ADDR_W-1:0];
            end
            if (wr_fire) begin
                wr_addr <= frame_now[FW-2 -: ADDR_W];
                wr_data <= frame_now[DATA_W-1:0];
            end
        end
    end

    // Transmit path: read data captured in the rd_req cycle, shifted out on
    // SCK falls while in DATA. The fall after the last rise lands in DONE and
    // is ignored, so exactly DATA_W bits are presented.
    always_ff @(posedge clk125 or negedge rst) begin
        if (!rst) begin
            tx      <= '0;
            tx_act  <= 1'b0;
            spi_sdo <= 1'b0;
        end else if (state_q == IDLE) begin
            tx      <= '0;
            tx_act  <= 1'b0;
            spi_sdo <= 1'b0;
        end else if (rd_req) begin
            tx     <= rd_data;
            tx_act <= 1'b1;
        end else if (state_q == DATA && sck_fall && tx_act) begin
            spi_sdo <= tx[DATA_W-1];
            tx      <= {tx[DATA_W-2:0], 1'b0};
        end
    end

`ifdef SPI_RESP_ABORT_CNT_EN
    logic abort;
    logic [7:0] abort_q;

    assign abort = csn_rise & (state_q == CMD || state_q == DATA);

    always_ff @(posedge clk125 or negedge rst) begin
        if (!rst) begin
            abort_q <= 8'd0;
        end else if (abort && abort_q != 8'hFF) begin
            abort_q <= abort_q + 8'd1;
        end
    end

    assign abort_cnt = abort_q;
`else
    assign abort_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_spi_resp_regs.sv
// tb/tb_spi_resp_regs.sv - self-checking bench for spi_resp_regs
module tb_spi_resp_regs;

`ifdef SPI_RESP_ABORT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk125 = 1'b0;
    logic       rst;
    logic       spi_csn;
    logic       spi_sck;
    logic       spi_sdi;
    logic       spi_sdo;
    logic       spi_sdo_oe;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] abort_cnt;

    spi_resp_regs #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk125     (clk125),
        .rst        (rst),
        .spi_csn    (spi_csn),
        .spi_sck    (spi_sck),
        .spi_sdi    (spi_sdi),
        .spi_sdo    (spi_sdo),
        .spi_sdo_oe (spi_sdo_oe),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .abort_cnt  (abort_cnt)
    );

    always #4 clk125 = ~clk125;

    // Register file stub: address 0x05 holds 0x3C, others hold addr ^ 0x5A.
    assign rd_data = (rd_addr == 7'h05) ? 8'h3C : ({1'b0, rd_addr} ^ 8'h5A);

    int         wr_total = 0;
    int         rd_total = 0;
    logic [6:0] cap_wa = '0;
    logic [7:0] cap_wd = '0;
    logic [6:0] cap_ra = '0;

    always @(negedge clk125) begin
        if (wr_en) begin
            wr_total <= wr_total + 1;
            cap_wa   <= wr_addr;
            cap_wd   <= wr_data;
        end
        if (rd_req) begin
            rd_total <= rd_total + 1;
            cap_ra   <= rd_addr;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [15:0] sdo_word;
    logic        oe_seen;

    // Mode-0 master, 10 MHz SCK. SDO sampled just before each rising edge.
    task automatic send(input logic [15:0] f, input int n);
        sdo_word = '0;
        oe_seen  = 1'b0;
        spi_csn  = 1'b0;
        #50;
        for (int i = 0; i < n; i++) begin
            spi_sdi = (i < 16) ? f[15-i] : 1'b0;
            #50;
            if (i < 16) sdo_word[15-i] = spi_sdo;
            if (i == 0) oe_seen = spi_sdo_oe;
            spi_sck = 1'b1;
            #50;
            spi_sck = 1'b0;
        end
        #50;
        spi_csn = 1'b1;
        spi_sdi = 1'b0;
        #200;
    endtask

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        int          wr_n;
        logic [6:0]  wa;
        logic [7:0]  wd;
        int          rd_n;
        logic [6:0]  ra;
        logic [15:0] sdo;
        int          ab;
    } vec_t;

    vec_t vt[9];

    initial begin
        int wr0, rd0, exp_ab;

        vt[0] = '{16'h12A5, 16, 1, 7'h12, 8'hA5, 0, 7'h00, 16'h0000, 0};
        vt[1] = '{16'h8500, 16, 0, 7'h00, 8'h00, 1, 7'h05, 16'h003C, 0};
        vt[2] = '{16'h3355, 11, 0, 7'h00, 8'h00, 0, 7'h00, 16'h0000, 1};
        vt[3] = '{16'h0781, 20, 1, 7'h07, 8'h81, 0, 7'h00, 16'h0000, 0};
        vt[4] = '{16'h9100, 16, 0, 7'h00, 8'h00, 1, 7'h11, 16'h004B, 0};
        vt[5] = '{16'h7FFF, 16, 1, 7'h7F, 8'hFF, 0, 7'h00, 16'h0000, 0};
        vt[6] = '{16'h0000, 16, 1, 7'h00, 8'h00, 0, 7'h00, 16'h0000, 0};
        vt[7] = '{16'h8A00, 10, 0, 7'h00, 8'h00, 1, 7'h0A, 16'h0040, 1};
        vt[8] = '{16'hFF00, 20, 0, 7'h00, 8'h00, 1, 7'h7F, 16'h0025, 0};

        rst     = 1'b0;
        spi_csn = 1'b1;
        spi_sck = 1'b0;
        spi_sdi = 1'b0;
        #20;
        chk("reset strobes", {30'd0, wr_en, rd_req}, 32'd0);
        chk("reset sdo/oe", {30'd0, spi_sdo, spi_sdo_oe}, 32'd0);
        chk("reset addr/data", {10'd0, wr_addr, wr_data, rd_addr}, 32'd0);
        chk("reset abort_cnt", {24'd0, abort_cnt}, 32'd0);
        @(negedge clk125);
        #1;
        rst = 1'b1;
        #40;

        exp_ab = 0;
        for (int i = 0; i < 9; i++) begin
            wr0 = wr_total;
            rd0 = rd_total;
            send(vt[i].frame, vt[i].nbits);
            if (CNT_EN) exp_ab += vt[i].ab;
            chk($sformatf("v%0d wr_cnt", i), wr_total - wr0, vt[i].wr_n);
            chk($sformatf("v%0d rd_cnt", i), rd_total - rd0, vt[i].rd_n);
            if (vt[i].wr_n == 1) begin
                chk($sformatf("v%0d wr_addr", i), {25'd0, cap_wa}, {25'd0, vt[i].wa});
                chk($sformatf("v%0d wr_data", i), {24'd0, cap_wd}, {24'd0, vt[i].wd});
            end
            if (vt[i].rd_n == 1) begin
                chk($sformatf("v%0d rd_addr", i), {25'd0, cap_ra}, {25'd0, vt[i].ra});
            end
            chk($sformatf("v%0d sdo_word", i), {16'd0, sdo_word}, {16'd0, vt[i].sdo});
            chk($sformatf("v%0d oe_in_frame", i), {31'd0, oe_seen}, 32'd1);
            chk($sformatf("v%0d idle sdo/oe", i), {30'd0, spi_sdo, spi_sdo_oe}, 32'd0);
            chk($sformatf("v%0d abort_cnt", i), {24'd0, abort_cnt}, exp_ab);
        end

        // SCK toggling while deselected must not do anything.
        wr0 = wr_total;
        rd0 = rd_total;
        spi_sdi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #50 spi_sck = 1'b1;
            #50 spi_sck = 1'b0;
        end
        spi_sdi = 1'b0;
        #200;
        chk("sck while deselected", (wr_total - wr0) + (rd_total - rd0), 32'd0);
        send(16'h2233, 16);
        chk("post-deselect wr_cnt", wr_total - wr0, 32'd1);
        chk("post-deselect wr", {17'd0, cap_wa, cap_wd}, {17'd0, 7'h22, 8'h33});

        // Reset during bit 12 of a write; the rest of that frame must be ignored.
        wr0 = wr_total;
        spi_csn = 1'b0;
        #50;
        for (int i = 0; i < 16; i++) begin
            spi_sdi = (16'h5A5A >> (15 - i)) & 16'd1;
            #50 spi_sck = 1'b1;
            #50 spi_sck = 1'b0;
            if (i == 11) begin
                #10 rst = 1'b0;
                #24 rst = 1'b1;
                #10;
            end
        end
        #50 spi_csn = 1'b1;
        spi_sdi = 1'b0;
        #200;
        chk("interrupted frame wr_cnt", wr_total - wr0, 32'd0);
        chk("abort_cnt after reset", {24'd0, abort_cnt}, 32'd0);
        send(16'h0102, 16);
        chk("after reset wr_cnt", wr_total - wr0, 32'd1);
        chk("after reset wr", {17'd0, cap_wa, cap_wd}, {17'd0, 7'h01, 8'h02});
        chk("after reset abort_cnt", {24'd0, abort_cnt}, 32'd0);

        // 300 empty frames, each aborted in CMD.
        for (int i = 0; i < 300; i++) begin
            spi_csn = 1'b0;
            #64;
            spi_csn = 1'b1;
            #64;
        end
        #100;
        chk("abort_cnt saturation", {24'd0, abort_cnt}, CNT_EN ? 32'd255 : 32'd0);
        chk("no strobes from aborts", wr_total - wr0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_resp_regs.md
SPI_RESP_REGS -- requirements
Module: spi_resp_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, register address width (command byte = 1 R/W bit + ADDR_W bits, so ADDR_W fixed to 7 for 8-bit command).
REQ-002 SHALL have parameter DATA_W, default 8, register data width.
REQ-003 SHALL have port clk125, input, 1: sole clock, 125 MHz system clock.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port spi_csn, input, 1: SPI chip select from external master, active-low, asynchronous to clk125.
REQ-006 SHALL have port spi_sck, input, 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk125.
REQ-007 SHALL have port spi_sdi, input, 1: master-to-responder data, MSB first.
REQ-008 SHALL have port spi_sdo, output, 1: responder-to-master data, MSB first.
REQ-009 SHALL have port spi_sdo_oe, output, 1: SDO drive enable, high only while selected.
REQ-010 SHALL have port wr_en, output, 1: one-cycle register write strobe.
REQ-011 SHALL have port wr_addr, output, ADDR_W: write address, valid with wr_en.
REQ-012 SHALL have port wr_data, output, DATA_W: write data, valid with wr_en.
REQ-013 SHALL have port rd_req, output, 1: one-cycle register read strobe.
REQ-014 SHALL have port rd_addr, output, ADDR_W: read address, valid with rd_req.
REQ-015 SHALL have port rd_data, input, DATA_W: read data, combinational from the register file, sampled in the rd_req cycle.
REQ-016 SHALL have port abort_cnt, output, 8: count of aborted frames (see Configuration).

Function
REQ-017 Frame SHALL be 16 bits: bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = data (write) or don't-care (read).
REQ-018 spi_csn, spi_sck and spi_sdi SHALL each pass through a 2-flop synchronizer; SCK edges SHALL be detected on the synchronized signal, giving 3 clk125 cycles of input latency.
REQ-019 Supported SCK SHALL be at most clk125/8; each SCK high and low phase SHALL be at least 4 clk125 cycles.
REQ-020 FSM states SHALL be IDLE, CMD, DATA, DONE; IDLE->CMD on synchronized CSN fall; CMD->DATA after the 8th SCK rise; DATA->DONE after the 16th SCK rise; any state->IDLE on synchronized CSN rise.
REQ-021 SDI SHALL be shifted in on each synchronized SCK rise; a 5-bit bit counter SHALL clear on CSN fall.
REQ-022 For a read, rd_req SHALL pulse for one cycle the cycle after the 8th SCK rise, with rd_addr = bits14:8; rd_data SHALL be loaded into the TX shift register in that same cycle.
REQ-023 spi_sdo SHALL present TX bit7 from the first SCK fall after rd_req and advance one bit per SCK fall; spi_sdo SHALL be 0 during CMD and for write frames.
REQ-024 For a write, wr_en SHALL pulse for one cycle the cycle after the 16th SCK rise, with wr_addr/wr_data from the frame.
REQ-025 SCK edges in DONE SHALL be ignored; no second write and no second rd_req SHALL occur within one frame.
REQ-026 CSN rise before the 16th SCK rise SHALL abort: no wr_en; FSM returns to IDLE; any rd_req already issued stands.
REQ-027 spi_sdo_oe SHALL equal the inverted synchronized CSN.
REQ-028 SCK edges while CSN is high SHALL be ignored.

Reset
REQ-029 On rst low all flops SHALL clear asynchronously: FSM = IDLE, synchronizers reset to CSN=1 and SCK/SDI=0, and spi_sdo, spi_sdo_oe, wr_en, rd_req = 0, wr_addr, wr_data, rd_addr = 0, abort_cnt = 0.
REQ-030 Reset release mid-frame SHALL keep the FSM in IDLE until the next CSN fall.

Configuration
REQ-031 With macro SPI_RESP_ABORT_CNT_EN defined, abort_cnt SHALL increment on each REQ-026 abort and saturate at 255; without it, abort_cnt SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-032 Write frame 0x12A5 at SCK = 10 MHz -> exactly one wr_en, wr_addr = 0x12, wr_data = 0xA5.
REQ-033 Read frame 0x8500 with rd_data = 0x3C when rd_addr = 0x05 -> one rd_req, rd_addr = 0x05, master samples 0x3C on SDO, no wr_en.
REQ-034 CSN rises after 11 bits of a write -> no wr_en; abort_cnt = 1 with SPI_RESP_ABORT_CNT_EN, 0 without.
REQ-035 20 SCK pulses in one write frame 0x0781 -> single wr_en, wr_addr = 0x07, wr_data = 0x81.
REQ-036 rst asserted at bit 12 of a write, released, then frame 0x0102 -> no write for the interrupted frame, then wr_addr = 0x01, wr_data = 0x02.
REQ-037 300 consecutive aborted frames with the macro defined -> abort_cnt = 255.
